// File: rtl/grayscale_pipe.sv
// RGB-to-grayscale streaming pipeline: channel expansion, BT.601-style weighting, frame FSM.
// Optional macro GS_BINARIZE_EN turns the last stage into a threshold (THRESH) binarizer.
module grayscale_pipe #(
  parameter int          R_W    = 5,
  parameter int          G_W    = 6,
  parameter int          B_W    = 5,
  parameter int unsigned NPIX   = 307200,
  parameter int          THRESH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic [R_W+G_W+B_W-1:0]   din,
  output logic                     in_ready,
  output logic [7:0]               dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done
);

  localparam int P_W = R_W + G_W + B_W;
  localparam int CW  = $clog2(NPIX + 1);

  if (R_W < 1 || R_W > 8 || G_W < 1 || G_W > 8 || B_W < 1 || B_W > 8) begin : g_bad_width
    $error("grayscale_pipe: channel widths must be 1..8");
  end
  if (NPIX < 1) begin : g_bad_npix
    $error("grayscale_pipe: NPIX must be at least 1");
  end
  if (THRESH < 0 || THRESH > 256) begin : g_bad_thresh
    $error("grayscale_pipe: THRESH must be 0..256");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;

  logic            s1_valid, s2_valid;
  logic [7:0]      s1_r, s1_g, s1_b;
  logic [15:0]     s2_pr, s2_pg, s2_pb;

  // A transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and adv freezes every stage while dout is held.
  logic adv, in_fire, abort, drained, last_xfer;

  assign adv       = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign abort     = !enable && (state_q == RUN || state_q == FLUSH);
  assign drained   = !s1_valid && !s2_valid && !out_valid;
  assign last_xfer = (count_q == CW'(NPIX - 1));

  // Channel fields and MSB-first bit replication up to 8 bits
  logic [R_W-1:0] r_f;
  logic [G_W-1:0] g_f;
  logic [B_W-1:0] b_f;
  logic [7:0]     r8, g8, b8;

  assign r_f = din[P_W-1 -: R_W];
  assign g_f = din[G_W+B_W-1 -: G_W];
  assign b_f = din[B_W-1:0];

  for (genvar k = 0; k < 8; k++) begin : g_expand
    assign r8[7-k] = r_f[R_W-1-(k%R_W)];
    assign g8[7-k] = g_f[G_W-1-(k%G_W)];
    assign b8[7-k] = b_f[B_W-1-(k%B_W)];
  end

  logic [15:0] sum_d;
  logic [7:0]  gray_d, result_d;

  assign sum_d  = s2_pr + s2_pg + s2_pb;
  assign gray_d = 8'(sum_d >> 8);

`ifdef GS_BINARIZE_EN
  assign result_d = ({1'b0, gray_d} >= 9'(THRESH)) ? 8'hFF : 8'h00;
`else
  assign result_d = gray_d;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
               else if (in_fire && last_xfer) state_d = FLUSH;
      FLUSH:   if (!enable) state_d = IDLE;
               else if (drained) state_d = DONE;
      DONE:    if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      RUN:     in_ready = adv;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Pixel counter stops at NPIX because RUN is left on the last transfer
  always_ff @(posedge clk) begin
    if (!rst_n)                          count_q <= '0;
    else if (state_q == IDLE && enable)  count_q <= '0;
    else if (state_q == RUN && in_fire)  count_q <= count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_fire;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_r  <= r8;
      s1_g  <= g8;
      s1_b  <= b8;
      s2_pr <= 16'(s1_r) * 16'd77;
      s2_pg <= 16'(s1_g) * 16'd150;
      s2_pb <= 16'(s1_b) * 16'd29;
    end
  end

  // dout only changes when a real pixel lands, so it stays stable between pixels
  always_ff @(posedge clk) begin
    if (!rst_n)               dout <= 8'h00;
    else if (adv && s2_valid) dout <= result_d;
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Bench for grayscale_pipe: scoreboard against an arithmetic reference model,
// one instance with NPIX=4 (frames, stalls, abort, reset) and one with NPIX=1.
module tb_grayscale_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_enable, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_done;
  logic [15:0] a_din;
  logic [7:0]  a_dout;

  logic        b_enable, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done;
  logic [15:0] b_din;
  logic [7:0]  b_dout;

  grayscale_pipe #(.NPIX(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(a_enable), .in_valid(a_in_valid), .din(a_din),
    .in_ready(a_in_ready), .dout(a_dout), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .done(a_done)
  );

  grayscale_pipe #(.NPIX(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .in_valid(b_in_valid), .din(b_din),
    .in_ready(b_in_ready), .dout(b_dout), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .done(b_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: replicate 5/6/5 fields to 8 bits, weight, divide by 256
  function automatic logic [7:0] model_gray(input logic [15:0] p);
    int r, g, b, r8, g8, b8, y;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = (r << 3) | (r >> 2);
    g8 = (g << 2) | (g >> 4);
    b8 = (b << 3) | (b >> 2);
    y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
`ifdef GS_BINARIZE_EN
    return (y >= 128) ? 8'hFF : 8'h00;
`else
    return 8'(y);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer, checks hold during stalls
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dout  = 8'h00;
  bit         lat_arm    = 1'b0;
  int         lat_out    = -1;

  always @(negedge clk) begin
    logic [7:0] e;
    #2;
    if (prev_stall) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_dout !== prev_dout) begin
        errors++;
        $display("FAIL stall_hold: out_valid=%0b dout=%h, required out_valid=1 dout=%h",
                 a_out_valid, a_dout, prev_dout);
      end
    end
    if (a_out_valid && !a_out_ready) check("stall_in_ready", 32'(a_in_ready), 32'd0);
    if (lat_arm && a_out_valid) begin
      lat_out = cyc;
      lat_arm = 1'b0;
    end
    if (a_out_valid && a_out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: dout=%h emitted, required no output", a_dout);
      end else begin
        e = exp_q.pop_front();
        if (a_dout !== e) begin
          errors++;
          $display("FAIL dout: got %h, required %h", a_dout, e);
        end
      end
    end
    prev_stall = a_out_valid && !a_out_ready && rst_n;
    prev_dout  = a_dout;
  end

  // mode 0: directed pixels, no backpressure; 1: 5-cycle stall mid-frame; 2: random
  task automatic run_frame(input int mode);
    logic [15:0] dir_pix[4];
    int  n_acc = 0, budget = 0, stall_left = 0, lat_in = 0;
    bit  seen_done = 1'b0, stall_done = 1'b0;
    dir_pix[0] = 16'hFFFF; dir_pix[1] = 16'hF800; dir_pix[2] = 16'h07E0; dir_pix[3] = 16'h001F;
    if (mode == 0) lat_arm = 1'b1;
    @(negedge clk);
    a_enable = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    while (!seen_done && budget < 300) begin
      @(negedge clk);
      budget++;
      case (mode)
        0: begin
          a_in_valid  = (n_acc < 4);
          a_din       = dir_pix[n_acc % 4];
          a_out_ready = 1'b1;
        end
        1: begin
          a_in_valid  = 1'b1;
          a_din       = 16'($urandom);
          a_out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: begin
          a_in_valid  = ($urandom_range(0, 9) < 7);
          a_din       = 16'($urandom);
          a_out_ready = ($urandom_range(0, 9) < 7);
        end
      endcase
      #1;
      if (n_acc == 4) check("no_accept_past_npix", 32'(a_in_ready), 32'd0);
      else if (a_in_valid && a_in_ready) begin
        exp_q.push_back(model_gray(a_din));
        if (n_acc == 0) lat_in = cyc;
        n_acc++;
        if (mode == 1 && n_acc == 2 && !stall_done) begin
          stall_left = 5;
          stall_done = 1'b1;
        end
      end
      if (a_done) seen_done = 1'b1;
    end
    a_in_valid = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL frame_done_timeout: done not seen after %0d cycles, required done=1", budget);
    end else begin
      check("pixels_accepted", 32'(n_acc), 32'd4);
      check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
      if (mode == 0) check("first_latency", 32'(lat_out - lat_in), 32'd3);
      @(negedge clk);
      a_out_ready = 1'b1;
      #1 check("done_level", 32'(a_done), 32'd1);
      a_enable = 1'b0;
      @(negedge clk);
      #1 check("done_falls", 32'(a_done), 32'd0);
    end
    a_enable = 1'b0;
    lat_arm  = 1'b0;
  endtask

  task automatic abort_test();
    int n = 0, budget = 0;
    @(negedge clk);
    a_enable = 1'b1; a_out_ready = 1'b1; a_in_valid = 1'b1;
    while (n < 2 && budget < 20) begin
      @(negedge clk);
      budget++;
      a_in_valid = 1'b1;
      a_din      = 16'($urandom);
      #1;
      if (a_in_ready) begin
        exp_q.push_back(model_gray(a_din));
        n++;
      end
    end
    check("abort_setup_pixels", 32'(n), 32'd2);
    @(negedge clk);
    a_enable = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    #3;
    check("abort_out_valid", 32'(a_out_valid), 32'd0);
    check("abort_in_ready", 32'(a_in_ready), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 check("abort_no_done", 32'(a_done), 32'd0);
    end
  endtask

  task automatic reset_test();
    int n = 0, budget = 0;
    @(negedge clk);
    a_enable = 1'b1; a_out_ready = 1'b1;
    while (n < 3 && budget < 20) begin
      @(negedge clk);
      budget++;
      a_in_valid = 1'b1;
      a_din      = 16'hFFFF;
      #1;
      if (a_in_ready) begin
        exp_q.push_back(model_gray(a_din));
        n++;
      end
    end
    check("reset_setup_pixels", 32'(n), 32'd3);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1 check("reset_pre_out_valid", 32'(a_out_valid), 32'd1);
    rst_n = 1'b0; a_enable = 1'b0;
    @(negedge clk);
    #3;
    check("reset_in_ready", 32'(a_in_ready), 32'd0);
    check("reset_out_valid", 32'(a_out_valid), 32'd0);
    check("reset_dout", 32'(a_dout), 32'd0);
    check("reset_done", 32'(a_done), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic npix1_test();
    bit got = 1'b0;
    @(negedge clk);
    b_enable = 1'b1; b_in_valid = 1'b1; b_din = 16'h0000; b_out_ready = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      #1 if (b_in_ready) got = 1'b1;
    end
    check("n1_transfer", 32'(got), 32'd1);
    @(negedge clk);
    #1 check("n1_in_ready_after", 32'(b_in_ready), 32'd0);
    b_in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (b_out_valid) begin
        got = 1'b1;
        check("n1_dout", 32'(b_dout), 32'(model_gray(16'h0000)));
      end else begin
        @(negedge clk);
        #1;
      end
    end
    check("n1_out_seen", 32'(got), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      #1 if (b_done) got = 1'b1;
    end
    check("n1_done", 32'(got), 32'd1);
    b_enable = 1'b0;
    @(negedge clk);
    #1 check("n1_done_falls", 32'(b_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL global_timeout: bench still running, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_enable = 1'b0; a_in_valid = 1'b0; a_din = '0; a_out_ready = 1'b1;
    b_enable = 1'b0; b_in_valid = 1'b0; b_din = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_dout", 32'(a_dout), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_b_done", 32'(b_done), 32'd0);
    rst_n = 1'b1;

    run_frame(0);
    run_frame(1);
    for (int i = 0; i < 12; i++) run_frame(2);
    abort_test();
    run_frame(2);
    reset_test();
    run_frame(1);
    npix1_test();

    repeat (5) @(negedge clk);
    #3 check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
